sdram_port_arb: RTL and testbench



---
 rtl/sdram_port_arb_pkg.sv | 16 +
 rtl/sdram_port_arb_timeout_cnt.sv | 31 +++
 rtl/sdram_port_arb.sv | 156 +++++++++++++++
 tb/tb_sdram_port_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arb_pkg.sv
// Shared constants and state encoding for the SDRAM port arbiter.
package sdram_port_arb_pkg;

    localparam int unsigned SDRAM_ADDR_NBIT = 24;
    localparam int unsigned SDRAM_DATA_NBIT = 32;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbWr   = 2'd1,
        ArbRd   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_port_arb_timeout_cnt.sv
// Command watchdog: clear/enable counter whose terminal flag marks the cycle
// on which the count reaches TIMEOUT.
module sdram_port_arb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic mclk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_NBIT = $clog2(TIMEOUT + 1);

    logic [CNT_NBIT-1:0] cnt_q;

    // Count cycles spent with a command outstanding.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_NBIT'(1);
        end
    end

    // High on the cycle whose increment would bring the count to TIMEOUT.
    assign tc = en && (cnt_q == CNT_NBIT'(TIMEOUT - 1));

endmodule

// File: rtl/sdram_port_arb.sv
// Two-port arbiter in front of sdram_ctrl: loader writes vs. player reads.
// Reads win unless the loader has waited through MAX_RD_RUN read grants.
module sdram_port_arb
    import sdram_port_arb_pkg::*;
#(
    parameter int unsigned DATA_NBIT  = SDRAM_DATA_NBIT,
    parameter int unsigned ADDR_NBIT  = SDRAM_ADDR_NBIT,
    parameter int unsigned MAX_RD_RUN = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic [ADDR_NBIT-1:0] wr_addr,
    input  logic [DATA_NBIT-1:0] wr_data,
    output logic                 wr_ack,
    output logic                 wr_err,
    input  logic                 rd_req,
    input  logic [ADDR_NBIT-1:0] rd_addr,
    output logic                 rd_ack,
    output logic [DATA_NBIT-1:0] rd_data,
    output logic                 rd_dv,
    output logic                 rd_err,
    output logic                 busy,
    output logic                 ctrl_wren,
    output logic [ADDR_NBIT-1:0] ctrl_waddr,
    output logic [DATA_NBIT-1:0] ctrl_wdata,
    input  logic                 ctrl_wstatus,
    output logic                 ctrl_rd,
    output logic [ADDR_NBIT-1:0] ctrl_raddr,
    input  logic [DATA_NBIT-1:0] ctrl_rdata,
    input  logic                 ctrl_rdv,
    input  logic                 ctrl_rstatus
);

    localparam int unsigned RUN_NBIT = $clog2(MAX_RD_RUN + 1);

    arb_state_t          state_q;
    logic [RUN_NBIT-1:0] rd_run_cnt_q;
    logic                seen_busy_q;

    logic grant_ok;
    logic grant_wr;
    logic grant_rd;
    logic run_full;
    logic tmo_clr;
    logic tmo_tc;

    // Grant decision taken from the requests sampled on this edge.
    always_comb begin
        run_full = (rd_run_cnt_q >= RUN_NBIT'(MAX_RD_RUN));
        grant_ok = (state_q == ArbIdle) && !ctrl_wstatus && !ctrl_rstatus;
        grant_wr = grant_ok && wr_req && (!rd_req || run_full);
        grant_rd = grant_ok && rd_req && !grant_wr;
        tmo_clr  = (state_q == ArbIdle);
    end

    sdram_port_arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .mclk (mclk),
        .rst  (rst),
        .clr  (tmo_clr),
        .en   (!tmo_clr),
        .tc   (tmo_tc)
    );

    // Arbiter FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q      <= ArbIdle;
            rd_run_cnt_q <= '0;
            seen_busy_q  <= LOW;
            wr_ack       <= LOW;
            wr_err       <= LOW;
            rd_ack       <= LOW;
            rd_data      <= '0;
            rd_dv        <= LOW;
            rd_err       <= LOW;
            busy         <= LOW;
            ctrl_wren    <= LOW;
            ctrl_waddr   <= '0;
            ctrl_wdata   <= '0;
            ctrl_rd      <= LOW;
            ctrl_raddr   <= '0;
        end else begin
            wr_ack    <= LOW;
            wr_err    <= LOW;
            rd_ack    <= LOW;
            rd_dv     <= LOW;
            rd_err    <= LOW;
            ctrl_wren <= LOW;
            ctrl_rd   <= LOW;

            // Run-length guard: a write grant or an idle loader resets the run.
            if (grant_wr || ((state_q == ArbIdle) && !wr_req)) begin
                rd_run_cnt_q <= '0;
            end else if (grant_rd && !run_full) begin
                rd_run_cnt_q <= rd_run_cnt_q + RUN_NBIT'(1);
            end

            case (state_q)
                ArbIdle: begin
                    seen_busy_q <= LOW;
                    if (grant_wr) begin
                        wr_ack     <= HIGH;
                        ctrl_wren  <= HIGH;
                        ctrl_waddr <= wr_addr;
                        ctrl_wdata <= wr_data;
                        busy       <= HIGH;
                        state_q    <= ArbWr;
                    end else if (grant_rd) begin
                        rd_ack     <= HIGH;
                        ctrl_rd    <= HIGH;
                        ctrl_raddr <= rd_addr;
                        busy       <= HIGH;
                        state_q    <= ArbRd;
                    end
                end
                ArbWr: begin
                    if (ctrl_wstatus) begin
                        seen_busy_q <= HIGH;
                    end
                    // Completion has priority over a coincident timeout.
                    if (!ctrl_wstatus && seen_busy_q) begin
                        busy        <= LOW;
                        seen_busy_q <= LOW;
                        state_q     <= ArbIdle;
                    end else if (tmo_tc) begin
                        wr_err      <= HIGH;
                        busy        <= LOW;
                        seen_busy_q <= LOW;
                        state_q     <= ArbIdle;
                    end
                end
                ArbRd: begin
                    if (ctrl_rdv) begin
                        rd_data <= ctrl_rdata;
                        rd_dv   <= HIGH;
                        busy    <= LOW;
                        state_q <= ArbIdle;
                    end else if (tmo_tc) begin
                        rd_err  <= HIGH;
                        busy    <= LOW;
                        state_q <= ArbIdle;
                    end
                end
                default: begin
                    busy    <= LOW;
                    state_q <= ArbIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb with a behavioural sdram_ctrl model and
// queue-based scoreboard of expected write/read transactions.
module tb_sdram_port_arb;

    logic        mclk;
    logic        rst;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_dv;
    logic        rd_err;
    logic        busy;
    logic        ctrl_wren;
    logic [23:0] ctrl_waddr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_wstatus;
    logic        ctrl_rd;
    logic [23:0] ctrl_raddr;
    logic [31:0] ctrl_rdata;
    logic        ctrl_rdv;
    logic        ctrl_rstatus;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rd_dv  = 0;
    int n_rd_ack = 0;
    int n_ctrl_rd = 0;

    logic [55:0] exp_wr[$];
    logic [23:0] exp_raddr[$];
    logic [31:0] exp_rdata[$];

    bit   model_rd_en;
    logic ws_at_edge, rs_at_edge, rdv_at_edge;

    sdram_port_arb #(
        .DATA_NBIT  (32),
        .ADDR_NBIT  (24),
        .MAX_RD_RUN (8),
        .TIMEOUT    (255)
    ) dut (
        .mclk         (mclk),
        .rst          (rst),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data),
        .rd_dv        (rd_dv),
        .rd_err       (rd_err),
        .busy         (busy),
        .ctrl_wren    (ctrl_wren),
        .ctrl_waddr   (ctrl_waddr),
        .ctrl_wdata   (ctrl_wdata),
        .ctrl_wstatus (ctrl_wstatus),
        .ctrl_rd      (ctrl_rd),
        .ctrl_raddr   (ctrl_raddr),
        .ctrl_rdata   (ctrl_rdata),
        .ctrl_rdv     (ctrl_rdv),
        .ctrl_rstatus (ctrl_rstatus)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_data(input logic [23:0] a);
        return 32'h0001_2365 ^ {8'h00, a};
    endfunction

    // Input values as seen by the DUT on each rising edge.
    always @(posedge mclk) begin
        ws_at_edge  <= ctrl_wstatus;
        rs_at_edge  <= ctrl_rstatus;
        rdv_at_edge <= ctrl_rdv;
    end

    // sdram_ctrl model: write engine busy 3 cycles, read data 5 cycles after ctrl_rd.
    initial begin
        int          w_left;
        int          r_left;
        logic [23:0] r_addr;
        w_left       = 0;
        r_left       = 0;
        r_addr       = '0;
        ctrl_wstatus = 1'b0;
        ctrl_rdv     = 1'b0;
        ctrl_rdata   = 32'hBAD0_BAD0;
        forever begin
            @(negedge mclk);
            ctrl_rdv   = 1'b0;
            ctrl_rdata = 32'hBAD0_BAD0;
            if (w_left > 0) begin
                w_left--;
                if (w_left == 0) ctrl_wstatus = 1'b0;
            end
            if (r_left > 0) begin
                r_left--;
                if (r_left == 0) begin
                    ctrl_rdv   = 1'b1;
                    ctrl_rdata = model_data(r_addr);
                end
            end
            if (ctrl_wren) begin
                ctrl_wstatus = 1'b1;
                w_left       = 3;
            end
            if (ctrl_rd && model_rd_en) begin
                r_left = 5;
                r_addr = ctrl_raddr;
            end
        end
    end

    // Scoreboard: compare every command and returned word against the queues.
    initial begin
        logic [55:0] e_wr;
        logic [23:0] e_ra;
        logic [31:0] e_rd;
        forever begin
            @(negedge mclk);
            if (ctrl_wren) begin
                check("wren_with_ack", wr_ack, 1);
                check("wr_grant_status_gate", {ws_at_edge, rs_at_edge}, 0);
                check("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e_wr = exp_wr.pop_front();
                    check("ctrl_waddr_wdata", {ctrl_waddr, ctrl_wdata}, e_wr);
                end
            end
            if (ctrl_rd) begin
                n_ctrl_rd++;
                check("rd_with_ack", rd_ack, 1);
                check("rd_grant_status_gate", {ws_at_edge, rs_at_edge}, 0);
                check("rd_expected", exp_raddr.size() != 0, 1);
                if (exp_raddr.size() != 0) begin
                    e_ra = exp_raddr.pop_front();
                    check("ctrl_raddr", ctrl_raddr, e_ra);
                end
            end
            if (rd_ack) n_rd_ack++;
            if (rd_dv) begin
                n_rd_dv++;
                check("rd_dv_after_rdv", rdv_at_edge, 1);
                check("rd_dv_expected", exp_rdata.size() != 0, 1);
                if (exp_rdata.size() != 0) begin
                    e_rd = exp_rdata.pop_front();
                    check("rd_data", rd_data, e_rd);
                end
            end
        end
    end

    task automatic issue_wr(input logic [23:0] a, input logic [31:0] d, input string tag);
        int n;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        exp_wr.push_back({a, d});
        n = 0;
        do begin @(negedge mclk); n++; end while (!wr_ack && n < 20);
        check({tag, "_ack_latency"}, n, 1);
        check({tag, "_wren"}, ctrl_wren, 1);
        wr_req = 1'b0;
    endtask

    task automatic issue_rd(input logic [23:0] a, input bit expect_data, input string tag);
        int n;
        rd_addr = a;
        rd_req  = 1'b1;
        exp_raddr.push_back(a);
        if (expect_data) exp_rdata.push_back(model_data(a));
        n = 0;
        do begin @(negedge mclk); n++; end while (!rd_ack && n < 20);
        check({tag, "_ack_latency"}, n, 1);
        check({tag, "_ctrl_rd"}, ctrl_rd, 1);
        rd_req = 1'b0;
    endtask

    initial begin
        int n;
        int dv_before;
        int ack_before;
        int crd_before;
        int rd_i;
        int wr_i;
        bit g[$];

        rst          = 1'b1;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        ctrl_rstatus = 1'b0;
        model_rd_en  = 1'b1;

        // Reset state
        repeat (3) @(negedge mclk);
        check("reset_pulses", {wr_ack, wr_err, rd_ack, rd_dv, rd_err, busy, ctrl_wren, ctrl_rd}, 0);
        check("reset_wbus", {ctrl_waddr, ctrl_wdata}, 0);
        check("reset_rbus", {ctrl_raddr, rd_data}, 0);
        rst = 1'b0;
        repeat (2) @(negedge mclk);

        // Single write
        issue_wr(24'h00_0010, 32'hDEAD_BEEF, "wr1");
        check("wr1_busy_on_grant", busy, 1);
        repeat (3) @(negedge mclk);
        check("wr1_busy_while_wstatus", busy, 1);
        @(negedge mclk);
        check("wr1_busy_drop", busy, 0);
        repeat (2) @(negedge mclk);

        // Single read
        dv_before = n_rd_dv;
        issue_rd(24'h00_0020, 1'b1, "rd1");
        n = 0;
        do begin @(negedge mclk); n++; end while (!rd_dv && n < 40);
        check("rd1_dv_latency", n, 6);
        check("rd1_data", rd_data, 32'h0001_2345);
        check("rd1_busy_drop", busy, 0);
        repeat (5) @(negedge mclk);
        #1;
        check("rd1_single_dv", n_rd_dv - dv_before, 1);
        @(negedge mclk);

        // Contention: both requesters held continuously
        rd_i = 0;
        wr_i = 0;
        rd_addr = 24'h00_0100;
        rd_req  = 1'b1;
        exp_raddr.push_back(rd_addr);
        exp_rdata.push_back(model_data(rd_addr));
        wr_addr = 24'h00_0200;
        wr_data = 32'hC0DE_0000;
        wr_req  = 1'b1;
        exp_wr.push_back({wr_addr, wr_data});
        n = 0;
        while (g.size() < 18 && n < 1000) begin
            @(negedge mclk);
            n++;
            if (rd_ack) begin
                g.push_back(1'b0);
                rd_i++;
                rd_addr = 24'h00_0100 + 24'(rd_i);
                exp_raddr.push_back(rd_addr);
                exp_rdata.push_back(model_data(rd_addr));
            end
            if (wr_ack) begin
                g.push_back(1'b1);
                wr_i++;
                wr_addr = 24'h00_0200 + 24'(wr_i);
                wr_data = 32'hC0DE_0000 + 32'(wr_i);
                exp_wr.push_back({wr_addr, wr_data});
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        void'(exp_raddr.pop_back());
        void'(exp_rdata.pop_back());
        void'(exp_wr.pop_back());
        check("contention_grants", g.size() >= 18, 1);
        for (int i = 0; i < 18 && i < g.size(); i++) begin
            check($sformatf("grant_order_%0d", i), g[i], (i % 9) == 8);
        end
        repeat (20) @(negedge mclk);

        // Timeout: model never returns data
        model_rd_en = 1'b0;
        dv_before   = n_rd_dv;
        issue_rd(24'h00_0040, 1'b0, "tmo");
        n = 0;
        do begin @(negedge mclk); n++; end while (!rd_err && n < 400);
        check("tmo_err_latency", n, 255);
        check("tmo_busy_drop", busy, 0);
        @(negedge mclk);
        check("tmo_err_pulse", rd_err, 0);
        model_rd_en = 1'b1;
        #1;
        check("tmo_no_dv", n_rd_dv - dv_before, 0);
        @(negedge mclk);
        issue_rd(24'h00_0044, 1'b1, "post_tmo");
        n = 0;
        do begin @(negedge mclk); n++; end while (!rd_dv && n < 40);
        check("post_tmo_dv_latency", n, 6);
        repeat (2) @(negedge mclk);

        // Busy gate with withdrawal
        ack_before   = n_rd_ack;
        crd_before   = n_ctrl_rd;
        ctrl_rstatus = 1'b1;
        rd_addr      = 24'h00_0060;
        rd_req       = 1'b1;
        repeat (10) @(negedge mclk);
        rd_req = 1'b0;
        @(negedge mclk);
        ctrl_rstatus = 1'b0;
        repeat (3) @(negedge mclk);
        #1;
        check("gate_no_ack", n_rd_ack - ack_before, 0);
        check("gate_no_ctrl_rd", n_ctrl_rd - crd_before, 0);
        @(negedge mclk);

        // Asynchronous reset in the middle of a read
        dv_before = n_rd_dv;
        issue_rd(24'h00_0080, 1'b1, "rst_rd");
        repeat (2) @(negedge mclk);
        check("rst_rd_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pulses", {wr_ack, wr_err, rd_ack, rd_dv, rd_err, busy, ctrl_wren, ctrl_rd}, 0);
        check("async_rst_wbus", {ctrl_waddr, ctrl_wdata}, 0);
        check("async_rst_rbus", {ctrl_raddr, rd_data}, 0);
        void'(exp_rdata.pop_back());
        @(negedge mclk);
        rst = 1'b0;
        repeat (8) @(negedge mclk);
        #1;
        check("rst_rd_no_dv", n_rd_dv - dv_before, 0);
        check("rst_rd_idle", busy, 0);

        // Everything expected has been consumed
        repeat (3) @(negedge mclk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("raddr_queue_empty", exp_raddr.size(), 0);
        check("rdata_queue_empty", exp_rdata.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
